nco_phase_pi: RTL
=================

// Module: nco_phase_pi
// PURPOSE
// Next-generation NCO phase generator for the Costas carrier loop. It takes the phase-detector
// feedback and applies a proportional-integral loop filter with runtime shifts and a saturating
// integrator, then a wrapping phase accumulator. It emits one phase word per sample to the
// sin/cos stage over AXI-Stream handshakes with backpressure. Free-run mode and phase-sync are supported.
// PARAMETERS
// WIDTH      16  feedback, frequency-word and phase-output width (signed two's complement)
// ACC_WIDTH  24  phase accumulator width; must be >= WIDTH
// INT_WIDTH  24  loop-filter integrator width; must be >= WIDTH
// PORTS
// clk              in   1          clock
// rst              in   1          reset, synchronous, active-high
// FREE_FREQ        in   WIDTH      signed centre frequency word, in phase-output LSBs per sample
// KP_SHIFT         in   4          proportional path arithmetic right shift
// KI_SHIFT         in   4          integral path arithmetic right shift
// FREE_RUN         in   1          1 = advance every free output slot, ignoring feedback
// phase_sync       in   1          single-cycle pulse: zero the accumulator and integrator
// feedback_tdata   in   WIDTH      signed phase-detector error
// feedback_tvalid  in   1          feedback beat valid
// feedback_tready  out  1          feedback beat accepted when tvalid & tready
// phase_tdata      out  WIDTH      signed phase word (top WIDTH bits of the accumulator)
// phase_tvalid     out  1          phase word valid
// phase_tready     in   1          downstream ready
// freq_tdata       out  WIDTH      frequency word used for the last output (monitor)
// BEHAVIOUR
// - Reset: acc=0, integ=0, phase_tdata=0, phase_tvalid=0, freq_tdata=0. Config is not sampled during rst.
// - slot_free = !phase_tvalid | phase_tready.
// - feedback_tready = slot_free & !FREE_RUN & !phase_sync & !rst.
// - advance = (feedback_tvalid & feedback_tready) | (FREE_RUN & slot_free & !phase_sync).
// - On advance, with fb = FREE_RUN ? 0 : feedback_tdata:
//     prop = fb >>> KP_SHIFT, sign-extended.
//     integ_n = sat_INT(integ + (fb >>> KI_SHIFT)); integ <= integ_n.
//     Integrator saturation clamps to [-2^(INT_WIDTH-1), 2^(INT_WIDTH-1)-1] and never wraps.
//     freq = sat_W(FREE_FREQ + prop + integ_n). Compute the sum at INT_WIDTH+2 bits, then clamp to the signed WIDTH range.
//     acc <= acc + (sext(freq) << (ACC_WIDTH-WIDTH)). The accumulator wraps modulo 2^ACC_WIDTH (no saturation).
//     phase_tdata <= acc_next[ACC_WIDTH-1 -: WIDTH]; freq_tdata <= freq; phase_tvalid <= 1.
// - No advance and phase_tready=1: phase_tvalid <= 0.
// - No advance and phase_tready=0: all outputs and state hold. phase_tdata stays stable while valid & !ready.
// - Latency: output is registered one cycle after the accepting edge. Throughput is 1 beat/cycle when phase_tready=1.
// - Free-run: the integrator is frozen (fb=0 adds 0), so the output steps by sat_W(FREE_FREQ+integ) per slot.
// - phase_sync (priority over advance, below rst): acc<=0, integ<=0, phase_tvalid<=0.
//     The beat offered in that cycle is not accepted. Config registers are untouched.
// - Runtime config changes take effect on the next advance. No glitch-free guarantee within a beat.
// TESTING (WIDTH=16, ACC_WIDTH=24, INT_WIDTH=24)
// 1 Reset, FREE_RUN=1, FREE_FREQ=0x4000, phase_tready=1 -> phase 0x4000,0x8000,0xC000,0x0000 on consecutive cycles (wrap).
// 2 FREE_RUN=0, FREE_FREQ=0x4000, KP=4, KI=15, fb=0x1000 x2 -> freq_tdata 0x4100; phase 0x4100, then 0x8200.
// 3 FREE_FREQ=0, KP=15, KI=0, fb=0x0100 x3 -> freq 0x0100,0x0200,0x0300; phase 0x0100,0x0300,0x0600.
// 4 FREE_FREQ=0x7FFF, KP=0, KI=0, fb=0x7FFF x300 -> freq_tdata stays 0x7FFF; integ clamps at 0x7FFFFF, never negative.
// 5 Output valid, phase_tready=0 for 5 cycles -> feedback_tready=0, phase_tdata/acc frozen; ready=1 -> sequence resumes unbroken.
// 6 phase_sync pulse mid-stream with feedback_tvalid=1 -> that beat not accepted, phase_tvalid=0 next cycle;
//     next beat fb=0, FREE_FREQ=0x4000 -> phase 0x4000.

Source files
------------

// File: rtl/nco_phase_pi_if.sv
// Stream bundle between the phase detector, the NCO phase generator and the sin/cos stage.
// The master side is the environment; the slave side is the NCO.
interface nco_phase_pi_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] feedback_tdata;
  logic                    feedback_tvalid;
  logic                    feedback_tready;
  logic signed [WIDTH-1:0] phase_tdata;
  logic                    phase_tvalid;
  logic                    phase_tready;
  logic signed [WIDTH-1:0] freq_tdata;

  modport master (
    output feedback_tdata, feedback_tvalid, phase_tready,
    input  feedback_tready, phase_tdata, phase_tvalid, freq_tdata
  );

  modport slave (
    input  feedback_tdata, feedback_tvalid, phase_tready,
    output feedback_tready, phase_tdata, phase_tvalid, freq_tdata
  );
endinterface

// File: rtl/nco_phase_pi.sv
// NCO phase generator: PI loop filter with a saturating integrator feeding a wrapping
// phase accumulator; one phase word per accepted feedback beat (or per free slot in free-run).
module nco_phase_pi #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24,
  parameter int INT_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] FREE_FREQ,
  input  logic [3:0]              KP_SHIFT,
  input  logic [3:0]              KI_SHIFT,
  input  logic                    FREE_RUN,
  input  logic                    phase_sync,
  nco_phase_pi_if.slave           s
);

  localparam logic signed [WIDTH-1:0]     W_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]     W_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [INT_WIDTH-1:0] I_MAX   = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic signed [INT_WIDTH-1:0] I_MIN   = {1'b1, {(INT_WIDTH-1){1'b0}}};
  localparam logic signed [INT_WIDTH+1:0] F_MAX   = (INT_WIDTH+2)'(W_MAX);
  localparam logic signed [INT_WIDTH+1:0] F_MIN   = (INT_WIDTH+2)'(W_MIN);
  localparam int                          ACC_SH  = ACC_WIDTH - WIDTH;

  logic signed [ACC_WIDTH-1:0] acc, acc_next, acc_inc;
  logic signed [INT_WIDTH-1:0] integ, integ_n;
  logic signed [INT_WIDTH:0]   isum;
  logic signed [INT_WIDTH+1:0] fsum;
  logic signed [WIDTH-1:0]     fb, prop_w, ki_w, freq;
  logic                        slot_free, advance;

  assign slot_free         = !s.phase_tvalid | s.phase_tready;
  assign s.feedback_tready = slot_free & !FREE_RUN & !phase_sync & !rst;
  assign advance           = (s.feedback_tvalid & s.feedback_tready)
                           | (FREE_RUN & slot_free & !phase_sync);

  always_comb begin
    fb     = FREE_RUN ? '0 : s.feedback_tdata;
    prop_w = fb >>> KP_SHIFT;
    ki_w   = fb >>> KI_SHIFT;

    // One guard bit is enough to detect integrator overflow; clamp instead of wrapping.
    isum = (INT_WIDTH+1)'(integ) + (INT_WIDTH+1)'(ki_w);
    if (isum[INT_WIDTH] != isum[INT_WIDTH-1])
      integ_n = isum[INT_WIDTH] ? I_MIN : I_MAX;
    else
      integ_n = isum[INT_WIDTH-1:0];

    fsum = (INT_WIDTH+2)'(FREE_FREQ) + (INT_WIDTH+2)'(prop_w) + (INT_WIDTH+2)'(integ_n);
    if (fsum > F_MAX)      freq = W_MAX;
    else if (fsum < F_MIN) freq = W_MIN;
    else                   freq = fsum[WIDTH-1:0];

    acc_inc  = ACC_WIDTH'(freq) <<< ACC_SH;
    acc_next = acc + acc_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc            <= '0;
      integ          <= '0;
      s.phase_tdata  <= '0;
      s.phase_tvalid <= 1'b0;
      s.freq_tdata   <= '0;
    end else if (phase_sync) begin
      acc            <= '0;
      integ          <= '0;
      s.phase_tvalid <= 1'b0;
    end else if (advance) begin
      acc            <= acc_next;
      integ          <= integ_n;
      s.phase_tdata  <= acc_next[ACC_WIDTH-1 -: WIDTH];
      s.freq_tdata   <= freq;
      s.phase_tvalid <= 1'b1;
    end else if (s.phase_tready) begin
      s.phase_tvalid <= 1'b0;
    end
  end

endmodule
